// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data memory unit.
// Size encodings, FSM states and the request bundle latched at accept.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] luif;
      logic        m2r;
      logic        lui;
   } req_t;

   function automatic logic is_misaligned(logic [1:0] size,
                                          logic [1:0] addr_lo);
      return ((size == SZ_H) && addr_lo[0]) ||
             ((size == SZ_W) && (addr_lo != 2'b00));
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the pipeline and the data memory unit.
// The pipeline side is the master, the memory unit is the slave.
interface dmem_if;

   logic        req_valid;
   logic        req_ready;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  size;
   logic        load_unsigned;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] luifield;
   logic        MemToReg;
   logic        lui;
   logic        rsp_valid;
   logic [31:0] DataOut;
   logic        mem_err;

   modport master (
      output req_valid, MemRead, MemWrite, size, load_unsigned,
      output Address, WriteData, luifield, MemToReg, lui,
      input  req_ready, rsp_valid, DataOut, mem_err
   );

   modport slave (
      input  req_valid, MemRead, MemWrite, size, load_unsigned,
      input  Address, WriteData, luifield, MemToReg, lui,
      output req_ready, rsp_valid, DataOut, mem_err
   );

endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
// Purely combinational; size 11 yields no enables and zero load data.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  be_o,
   output logic [31:0] wword_o,
   output logic [31:0] ldata_o
);

   logic [31:0] sh_w;

   assign sh_w = rword_i >> {lane_i, 3'b000};

   // store enables/replication and load extraction per access size
   always_comb begin
      be_o    = 4'b0000;
      wword_o = '0;
      ldata_o = '0;
      unique case (1'b1)
         (size_i == SZ_B): begin
            be_o    = 4'b0001 << lane_i;
            wword_o = {4{wdata_i[7:0]}};
            ldata_o = {{24{~uns_i & sh_w[7]}}, sh_w[7:0]};
         end
         (size_i == SZ_H): begin
            be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
            wword_o = {2{wdata_i[15:0]}};
            ldata_o = {{16{~uns_i & sh_w[15]}}, sh_w[15:0]};
         end
         (size_i == SZ_W): begin
            be_o    = 4'b1111;
            wword_o = wdata_i;
            ldata_o = rword_i;
         end
         default: begin
            be_o    = 4'b0000;
         end
      endcase
   end

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory with wait states and writeback selection.
// Responses and stores happen on the edge that enters RESP.
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic  clk,
   input  logic  rst_n,
   dmem_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   state_e      st_q, st_d;
   logic [3:0]  cnt_q, cnt_d;
   req_t        req_q, live_w, cur_w;
   logic [31:0] dout_q;
   logic        err_q;
   logic [31:0] mem_q [DEPTH];

   logic          acc_w, memop_w, err_w, go_resp_w;
   logic [AW-1:0] idx_w;
   logic [3:0]    be_w;
   logic [31:0]   rword_w, wword_w, ldata_w, wb_w;

   assign live_w = '{
      rd:    bus.MemRead,
      wr:    bus.MemWrite,
      size:  bus.size,
      uns:   bus.load_unsigned,
      addr:  bus.Address,
      wdata: bus.WriteData,
      luif:  bus.luifield,
      m2r:   bus.MemToReg,
      lui:   bus.lui
   };

   assign bus.req_ready = (st_q == IDLE) || (st_q == RESP);
   assign bus.rsp_valid = (st_q == RESP);
   assign bus.DataOut   = dout_q;
   assign bus.mem_err   = err_q;

   // live fields on accept, latched fields while waiting
   assign acc_w   = bus.req_valid & bus.req_ready;
   assign cur_w   = acc_w ? live_w : req_q;
   assign memop_w = cur_w.rd | cur_w.wr;
   assign err_w   = memop_w &
                    ((cur_w.size == 2'b11) |
                     is_misaligned(cur_w.size, cur_w.addr[1:0]) |
                     (|cur_w.addr[31:AW+2]));
   assign idx_w   = cur_w.addr[AW+1:2];
   assign rword_w = mem_q[idx_w];

   dmem_lane_fmt u_fmt (
      .size_i  (cur_w.size),
      .lane_i  (cur_w.addr[1:0]),
      .uns_i   (cur_w.uns),
      .wdata_i (cur_w.wdata),
      .rword_i (rword_w),
      .be_o    (be_w),
      .wword_o (wword_w),
      .ldata_o (ldata_w)
   );

   assign wb_w = cur_w.m2r ? ldata_w :
                 cur_w.lui ? cur_w.luif : cur_w.addr;

   // next state, wait counter and the RESP-entry strobe
   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      go_resp_w = 1'b0;
      if (acc_w) begin
         if (err_w || !memop_w || (WAIT_STATES == 0)) begin
            st_d      = RESP;
            go_resp_w = 1'b1;
         end else begin
            st_d  = WAIT;
            cnt_d = 4'(WAIT_STATES - 1);
         end
      end else begin
         unique case (st_q)
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  st_d      = RESP;
                  go_resp_w = 1'b1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            RESP:    st_d = IDLE;
            default: st_d = st_q;
         endcase
      end
   end

   // FSM state and wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= IDLE;
         cnt_q <= 4'd0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   // request latch and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q  <= '0;
         dout_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (acc_w) req_q <= live_w;
         if (go_resp_w) begin
            dout_q <= err_w ? 32'd0 : wb_w;
            err_q  <= err_w;
         end
      end
   end

   // byte-lane store, committed on entry to RESP
   always_ff @(posedge clk) begin
      if (go_resp_w && cur_w.wr && !err_w) begin
         for (int i = 0; i < 4; i++) begin
            if (be_w[i]) mem_q[idx_w][8*i +: 8] <= wword_w[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench: three units with 0, 2 and 3 wait states.
// Unit 1 is tracked by a byte-array reference model under random traffic.
module tb_data_mem_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  vld = '0;
   logic        rd = 0, wr = 0, uns = 0, m2r = 0, lu = 0;
   logic [1:0]  sz = '0;
   logic [31:0] addr = '0, wd = '0, luif = '0;

   logic [2:0]  rdy, rv, err;
   logic [31:0] dout [3];

   int ncmp = 0;
   int nbad = 0;

   logic [7:0] mb [128];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gd
      localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;
      dmem_if bi ();
      assign bi.req_valid     = vld[g];
      assign bi.MemRead       = rd;
      assign bi.MemWrite      = wr;
      assign bi.size          = sz;
      assign bi.load_unsigned = uns;
      assign bi.Address       = addr;
      assign bi.WriteData     = wd;
      assign bi.luifield      = luif;
      assign bi.MemToReg      = m2r;
      assign bi.lui           = lu;
      assign rdy[g]  = bi.req_ready;
      assign rv[g]   = bi.rsp_valid;
      assign err[g]  = bi.mem_err;
      assign dout[g] = bi.DataOut;
      data_mem_unit #(.DEPTH(32), .WAIT_STATES(W)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bi)
      );
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      ncmp++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one request on unit d, starting and ending on a falling edge
   task automatic txn(input int d, input logic r, input logic w,
                      input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] wv,
                      input logic [31:0] lf, input logic mr,
                      input logic l, output logic [31:0] o,
                      output logic e, output int lat, output int wt);
      rd = r; wr = w; sz = s; uns = u; addr = a;
      wd = wv; luif = lf; m2r = mr; lu = l;
      vld[d] = 1'b1;
      wt = 0;
      lat = 0;
      o = '0;
      e = 1'b0;
      while (!rdy[d] && wt < 50) begin
         @(negedge clk);
         wt++;
      end
      if (!rdy[d]) begin
         chk("ready_timeout", 32'd0, 32'd1);
         vld[d] = 1'b0;
      end else begin
         @(negedge clk);
         vld[d] = 1'b0;
         lat = 1;
         while (!rv[d] && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         o = dout[d];
         e = err[d];
      end
   endtask

   // reference behaviour of the 2-wait-state unit, byte-granular
   task automatic model(input logic r, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] a,
                        input logic [31:0] wv, input logic [31:0] lf,
                        input logic mr, input logic l,
                        output logic [31:0] eo, output logic ee,
                        output int el);
      int n;
      longint v;
      n = 1 << s;
      v = 0;
      ee = (r || w) && (s == 2'b11 || (a % n) != 0 || a >= 128);
      if (s != 2'b11 && a < 128 && (a % n) == 0) begin
         for (int i = 0; i < n; i++) v += longint'(mb[a + i]) << (8 * i);
         if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
      end
      eo = ee ? 32'd0 : mr ? v[31:0] : l ? lf : a;
      if (w && !ee)
         for (int i = 0; i < n; i++) mb[a + i] = 8'(wv >> (8 * i));
      el = (ee || !(r || w)) ? 1 : 3;
   endtask

   task automatic op1(input string tag, input logic r, input logic w,
                      input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] wv,
                      input logic [31:0] lf, input logic mr,
                      input logic l, output logic [31:0] o,
                      output logic e, output int lat);
      logic [31:0] eo;
      logic        ee;
      int          el, wt;
      model(r, w, s, u, a, wv, lf, mr, l, eo, ee, el);
      txn(1, r, w, s, u, a, wv, lf, mr, l, o, e, lat, wt);
      chk({tag, "_dout"}, o, eo);
      chk({tag, "_err"}, 32'(e), 32'(ee));
      chk({tag, "_lat"}, lat, el);
   endtask

   initial begin
      logic [31:0] o;
      logic        e;
      int          lat, wt;

      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("rst_ready", 32'(rdy[i]), 32'd1);
         chk("rst_rsp", 32'(rv[i]), 32'd0);
         chk("rst_dout", dout[i], 32'd0);
         chk("rst_err", 32'(err[i]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 32; i++)
         op1("init", 0, 1, 2'b10, 0, 32'(4 * i), $urandom, 0, 0, 0, o, e, lat);

      op1("sw10", 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, o, e, lat);
      chk("sw10_lat_k", lat, 3);
      chk("sw10_err_k", 32'(e), 32'd0);
      op1("lw10", 1, 0, 2'b10, 0, 32'h10, 0, 0, 1, 0, o, e, lat);
      chk("lw10_k", o, 32'hDEADBEEF);
      op1("lb13", 1, 0, 2'b00, 0, 32'h13, 0, 0, 1, 0, o, e, lat);
      chk("lb13_k", o, 32'hFFFFFFDE);
      op1("lbu13", 1, 0, 2'b00, 1, 32'h13, 0, 0, 1, 0, o, e, lat);
      chk("lbu13_k", o, 32'h000000DE);
      op1("lh12", 1, 0, 2'b01, 0, 32'h12, 0, 0, 1, 0, o, e, lat);
      chk("lh12_k", o, 32'hFFFFDEAD);
      op1("lhu10", 1, 0, 2'b01, 1, 32'h10, 0, 0, 1, 0, o, e, lat);
      chk("lhu10_k", o, 32'h0000BEEF);
      op1("sh12", 0, 1, 2'b01, 0, 32'h12, 32'h1234, 0, 0, 0, o, e, lat);
      op1("lw_sh", 1, 0, 2'b10, 0, 32'h10, 0, 0, 1, 0, o, e, lat);
      chk("lw_sh_k", o, 32'h1234BEEF);
      op1("sb11", 0, 1, 2'b00, 0, 32'h11, 32'h77, 0, 0, 0, o, e, lat);
      op1("lw_sb", 1, 0, 2'b10, 0, 32'h10, 0, 0, 1, 0, o, e, lat);
      chk("lw_sb_k", o, 32'h123477EF);
      op1("lw11", 1, 0, 2'b10, 0, 32'h11, 0, 0, 1, 0, o, e, lat);
      chk("lw11_err_k", 32'(e), 32'd1);
      chk("lw11_dout_k", o, 32'd0);
      chk("lw11_lat_k", lat, 1);
      op1("sw80", 0, 1, 2'b10, 0, 32'h80, 32'h5555AAAA, 0, 0, 0, o, e, lat);
      chk("sw80_err_k", 32'(e), 32'd1);
      op1("lw_keep", 1, 0, 2'b10, 0, 32'h10, 0, 0, 1, 0, o, e, lat);
      chk("lw_keep_k", o, 32'h123477EF);
      op1("rmw", 1, 1, 2'b10, 0, 32'h10, 32'h0BADF00D, 0, 1, 0, o, e, lat);
      chk("rmw_old_k", o, 32'h123477EF);
      op1("lw_rmw", 1, 0, 2'b10, 0, 32'h10, 0, 0, 1, 0, o, e, lat);
      chk("lw_rmw_k", o, 32'h0BADF00D);

      for (int k = 0; k < 300; k++) begin
         logic        r, w, u, mr, l;
         logic [1:0]  s;
         logic [31:0] a;
         int          kind;
         kind = $urandom_range(0, 9);
         u  = 1'($urandom);
         mr = 1'($urandom);
         l  = 1'($urandom);
         if (kind == 0) begin
            r = 0; w = 0; s = 2'b10;
            a = 32'(4 * $urandom_range(0, 31));
         end else begin
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1;
            s = 2'($urandom_range(0, 3));
            a = (kind == 1) ? $urandom : 32'($urandom_range(0, 127));
            if (kind > 3 && s != 2'b11) a = a & ~((32'd1 << s) - 1);
         end
         op1("rnd", r, w, s, u, a, $urandom, $urandom, mr, l, o, e, lat);
      end

      txn(0, 0, 0, 2'b10, 0, 32'h0, 0, 32'hABCD0000, 0, 1, o, e, lat, wt);
      chk("lui_dout", o, 32'hABCD0000);
      chk("lui_lat", lat, 1);
      txn(0, 0, 1, 2'b10, 0, 32'h40, 32'h55AA33CC, 0, 0, 0, o, e, lat, wt);
      chk("b2b_sw_wait", wt, 0);
      chk("b2b_sw_lat", lat, 1);
      chk("b2b_sw_dout", o, 32'h40);
      txn(0, 1, 0, 2'b10, 0, 32'h40, 0, 0, 1, 0, o, e, lat, wt);
      chk("b2b_lw_wait", wt, 0);
      chk("b2b_lw_lat", lat, 1);
      chk("b2b_lw_dout", o, 32'h55AA33CC);

      txn(2, 0, 1, 2'b10, 0, 32'h20, 32'h11112222, 0, 0, 0, o, e, lat, wt);
      chk("ws3_lat", lat, 4);
      rd = 0; wr = 1; sz = 2'b10; uns = 0; addr = 32'h20;
      wd = 32'hCAFEF00D; m2r = 0; lu = 0;
      vld[2] = 1'b1;
      @(negedge clk);
      vld[2] = 1'b0;
      @(negedge clk);
      chk("in_wait_ready", 32'(rdy[2]), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(rdy[2]), 32'd1);
      chk("mid_rst_rsp", 32'(rv[2]), 32'd0);
      chk("mid_rst_dout", dout[2], 32'd0);
      chk("mid_rst_err", 32'(err[2]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      txn(2, 1, 0, 2'b10, 0, 32'h20, 0, 0, 1, 0, o, e, lat, wt);
      chk("abandon_dout", o, 32'h11112222);
      chk("abandon_lat", lat, 4);

      $display("test done: total=%0d bad=%0d", ncmp, nbad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
